add_share_ctrl: RTL

- Round-robin controller that shares one combinational DW-bit adder (a, b -> sum, DW+1 bits) between NUM_REQ requesters.
- Arbitrates valid/ready requests and drives the adder operands from registered copies.
- Captures the sum and returns it with the winning requester's id over a valid/ready response channel.
- Sits between testbench/agent requesters and the shared add datapath.

---
 rtl/add_share_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/add_share_ctrl.sv
// Round-robin controller sharing one external combinational adder between NUM_REQ requesters.
// Operands are registered before reaching the adder; the sum is returned with the winner's id.
module add_share_ctrl #(
    parameter  int NUM_REQ = 4,
    parameter  int DW      = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         add_a,
    output logic [DW-1:0]         add_b,
    input  logic [DW:0]           add_sum,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW:0]           rsp_sum,
    input  logic                  rsp_ready,
    output logic                  busy
);

    // state | meaning
    // IDLE  | arbitrating; winner accepted at the clock edge
    // LOAD  | registered operands launched into the shared adder
    // CALC  | adder settled; sum captured into the response at the edge
    // RESP  | response held until rsp_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [DW-1:0]  r_add_a;
    logic [DW-1:0]  r_add_b;
    logic [DW:0]    r_rsp_sum;
    logic [IDW-1:0] r_rsp_id;
    logic           r_rsp_valid;
    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_win_nxt;
    logic           w_accept;
    logic           w_rsp_hs;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDW'(sum);
    endfunction

    // First valid requester scanning upward from the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[rr_idx(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_rr_ptr, i);
            end
        end
    end

    assign w_accept  = (r_state == ST_IDLE) && w_found;
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;
    assign w_win_nxt = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept && rst_n) req_ready[w_win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_found)  w_next_state = ST_LOAD;
            ST_LOAD:               w_next_state = ST_CALC;
            ST_CALC:               w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_next_state = ST_IDLE;
            default:               w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_add_a  <= req_a[w_win*DW +: DW];
                r_add_b  <= req_b[w_win*DW +: DW];
                r_id     <= w_win;
                r_rr_ptr <= w_win_nxt;
            end
            if (r_state == ST_CALC) begin
                r_rsp_sum   <= add_sum;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end else if (r_state == ST_RESP && w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = r_rsp_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule
